axi_brom_rd_ctrl: RTL

- AXI4 read-only slave that converts AR/R bursts into native BRAM reads. Sits directly upstream of the native BRAM instance holding the boot ROM image.
- Drives the BRAM byte address and enable. Absorbs the BRAM's 1-cycle registered-address read latency with a small response FIFO, so R backpressure never loses data.
- Writes are not handled here; the top level ties the BRAM write strobes and write data to zero.

---
 rtl/axi_brom_pkg.sv | 43 ++++
 rtl/brom_rsp_fifo.sv | 50 +++++
 rtl/axi_brom_rd_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axi_brom_pkg.sv
// Shared types and address-sequencing helper for the boot-ROM AXI read controller.
// next_addr works on a 32-bit address; callers zero-extend and truncate to their BRAM width.
package axi_brom_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         ADDR_MAX_W = 32;

  // size must already be clamped to the line width by the caller.
  function automatic logic [ADDR_MAX_W-1:0] next_addr(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input burst_t                burst
  );
    logic [ADDR_MAX_W-1:0] beat;
    logic [ADDR_MAX_W-1:0] incr;
    logic [ADDR_MAX_W-1:0] mask;
    logic                  wrap_ok;
    beat    = ADDR_MAX_W'(1) << size;
    incr    = addr + beat;
    mask    = ((ADDR_MAX_W'(len) + ADDR_MAX_W'(1)) << size) - ADDR_MAX_W'(1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      next_addr = (addr & ~mask) | (incr & mask);
    end
  endfunction

endpackage

// File: rtl/brom_rsp_fifo.sv
// Three-entry response FIFO holding {rlast, rdata} for BRAM read returns.
// Upstream credit logic guarantees push never arrives while full.
module brom_rsp_fifo #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);
  localparam int DEPTH = 3;

  logic [W-1:0] mem [DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign do_pop = pop && (count != 2'd0);
  assign empty  = (count == 2'd0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_brom_rd_ctrl.sv
// AXI4 read-only slave feeding a native BRAM boot ROM; one burst outstanding at a time.
// Handshakes: a transfer occurs on a rising edge where valid && ready; valid never waits on ready.
module axi_brom_rd_ctrl
  import axi_brom_pkg::*;
#(
  parameter int MEM_DATA_WIDTH  = 128,
  parameter int BRAM_ADDR_WIDTH = 16,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int ID_WIDTH        = 4
) (
  input  logic                       clka,
  input  logic                       rsta_n,
  input  logic [ID_WIDTH-1:0]        s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [ID_WIDTH-1:0]        s_axi_rid,
  output logic [MEM_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic                       bram_en,
  input  logic [MEM_DATA_WIDTH-1:0]  bram_dout
);
  localparam int         LINE_OFFS = $clog2(MEM_DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE  = 3'(LINE_OFFS);

  state_t                     state_q, state_d;
  logic [ID_WIDTH-1:0]        id_q;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_nx, start_addr, align_mask;
  logic [7:0]                 len_q, beat_q;
  logic [2:0]                 size_q, size_in;
  burst_t                     burst_q, burst_in;
  logic                       en_q, last_q, issue_last;
  logic [1:0]                 fifo_count;
  logic                       fifo_empty, pop;
  logic [MEM_DATA_WIDTH:0]    fifo_head;
  logic [ADDR_MAX_W-1:0]      nx_full;

  // Oversized beats collapse to a full line; upper AXI address bits alias.
  assign size_in    = (s_axi_arsize > MAX_SIZE) ? MAX_SIZE : s_axi_arsize;
  assign burst_in   = burst_t'(s_axi_arburst);
  assign align_mask = ~((BRAM_ADDR_WIDTH'(1) << size_in) - BRAM_ADDR_WIDTH'(1));
  assign start_addr = (burst_in == BURST_FIXED) ? s_axi_araddr[BRAM_ADDR_WIDTH-1:0]
                                                : (s_axi_araddr[BRAM_ADDR_WIDTH-1:0] & align_mask);
  assign nx_full    = next_addr(ADDR_MAX_W'(addr_q), size_q, len_q, burst_q);
  assign addr_nx    = nx_full[BRAM_ADDR_WIDTH-1:0];
  assign issue_last = (beat_q == len_q);
  assign bram_addr  = addr_q;

  assign s_axi_rvalid = !fifo_empty;
  assign s_axi_rdata  = fifo_head[MEM_DATA_WIDTH-1:0];
  assign s_axi_rlast  = fifo_head[MEM_DATA_WIDTH] && !fifo_empty;
  assign s_axi_rid    = id_q;
  assign s_axi_rresp  = RESP_OKAY;
  assign pop          = s_axi_rvalid && s_axi_rready;

  always_comb begin
    state_d       = state_q;
    s_axi_arready = 1'b0;
    bram_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Data already queued plus the read in flight must leave a free slot.
        bram_en = ({1'b0, fifo_count} + {2'b00, en_q}) < 3'd3;
        if (bram_en && issue_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && s_axi_rlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      beat_q  <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= bram_en;
      last_q  <= bram_en && issue_last;
      if (s_axi_arvalid && s_axi_arready) begin
        id_q    <= s_axi_arid;
        addr_q  <= start_addr;
        len_q   <= s_axi_arlen;
        size_q  <= size_in;
        burst_q <= burst_in;
        beat_q  <= '0;
      end else if (bram_en) begin
        addr_q <= addr_nx;
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  brom_rsp_fifo #(.W(MEM_DATA_WIDTH + 1)) u_fifo (
    .clk   (clka),
    .rst_n (rsta_n),
    .push  (en_q),
    .din   ({last_q, bram_dout}),
    .pop   (pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
